// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Decoupled instruction-fetch front end for the 8-bit accumulator CPU.
// Issues sequential fetch requests to a synchronous instruction memory with a
// fixed 1-cycle read latency. Returned instructions go into a small prefetch
// FIFO and are handed to execute over a valid/ready handshake. A flush
// (taken jump) empties the FIFO, drops the in-flight response and reloads the
// fetch PC.
//
// Requests are credit-limited: one is only issued while (FIFO entries +
// outstanding response) < DEPTH, so a returning response always has a slot.
//
// Build option:
//   FETCH_BYPASS_EN - when defined, a response arriving while the FIFO is
//                     empty is shown on instr/instr_pc in the same cycle
//                     (accept-to-valid latency 1 instead of 2). If execute
//                     takes it that cycle it is never written to the FIFO.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-low reset
//   fetch_en     in   allow new memory requests
//   flush        in   redirect strobe (jump taken)
//   flush_pc     in   redirect target, valid with flush
//   imem_req     out  memory read request
//   imem_addr    out  request address (current fetch PC)
//   imem_gnt     in   memory accepts the request this cycle
//   imem_rvalid  in   read data valid, 1 cycle after an accepted request
//   imem_rdata   in   read data
//   instr_valid  out  instruction available to execute
//   instr        out  head instruction, 0x00 (NOP) when empty
//   instr_pc     out  address of instr
//   instr_ready  in   execute consumes instr this cycle
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  flush_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Fetch state
    logic [ADDR_W-1:0]  pc_q;
    logic               pend_q;      // a response is due next cycle
    logic [ADDR_W-1:0]  pend_pc_q;   // PC of that response

    // Prefetch FIFO
    logic [INSTR_W-1:0] fifo_instr [DEPTH];
    logic [ADDR_W-1:0]  fifo_pc    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;

    // Combinational control
    logic [CNT_W:0]     inflight;
    logic               credit_ok;
    logic               fifo_empty;
    logic               accept;
    logic               rsp_ok;
    logic               bypass;
    logic               pop;
    logic               push;
    logic               fifo_pop;

    assign inflight   = {1'b0, count_q} + {{CNT_W{1'b0}}, pend_q};
    assign credit_ok  = inflight < (CNT_W+1)'(DEPTH);
    assign fifo_empty = (count_q == '0);

    assign imem_req   = fetch_en && !flush && credit_ok;
    assign imem_addr  = pc_q;
    assign accept     = imem_req && imem_gnt;

    // A response counts only if we are actually waiting for one; anything
    // else is stale (pre-flush or pre-reset) and is ignored.
    assign rsp_ok     = imem_rvalid && pend_q && !flush;

`ifdef FETCH_BYPASS_EN
    assign bypass     = fifo_empty && rsp_ok;
`else
    assign bypass     = 1'b0;
`endif

    assign instr_valid = (!fifo_empty && !flush) || bypass;
    assign pop         = instr_valid && instr_ready;
    // A bypassed response that is consumed immediately never enters the FIFO.
    assign push        = rsp_ok && !(bypass && instr_ready);
    assign fifo_pop    = pop && !bypass;

    // NOTE: every output of a combinational block gets a default first, so
    // no path through it can leave a value unassigned and infer a latch.
    always_comb begin
        instr    = '0;
        instr_pc = '0;
        if (bypass) begin
            instr    = imem_rdata;
            instr_pc = pend_pc_q;
        end else if (!fifo_empty) begin
            instr    = fifo_instr[rd_ptr_q];
            instr_pc = fifo_pc[rd_ptr_q];
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= '0;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else if (flush) begin
            // Redirect wins over everything: drop FIFO, in-flight response
            // and any pop requested this cycle.
            pc_q      <= flush_pc;
            pend_q    <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            pend_q <= accept;
            if (accept) begin
                pc_q      <= pc_q + ADDR_W'(1);
                pend_pc_q <= pc_q;
            end
            if (push)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (fifo_pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, fifo_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; count/pointers gate every read, so
    // stale contents are never visible and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr_q] <= imem_rdata;
            fifo_pc[wr_ptr_q]    <= pend_pc_q;
        end
    end

endmodule
